wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 96 +++++++++
 tb/tb_wptr_full_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full/level logic for a dual-clock queue.
// Tracks the write pointer and compares it with a synchronized Gray read pointer.
module wptr_full_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int AF_LEVEL    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              w_clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_gray_async,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [ADDR_W:0]   w_gray,
  output logic              full_flag,
  output logic              almost_full,
  output logic [ADDR_W:0]   w_level,
  output logic              overflow
);

  localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LEVEL);

  // Handshake: w_en is the producer's valid and ~full_flag is the ready;
  // a write transfers on a w_clk edge only when both are high. w_en while
  // full is dropped and recorded in the sticky overflow flag.

  logic [ADDR_W:0] w_bin;
  logic [ADDR_W:0] w_bin_next;
  logic [ADDR_W:0] w_gray_next;
  logic [ADDR_W:0] w_level_next;
  logic [ADDR_W:0] rq_last;
  logic [ADDR_W:0] rq_bin;
  logic [ADDR_W:0] full_match;
  logic [ADDR_W:0] rq_sync [SYNC_STAGES];
  logic            w_inc;
  logic            full_next;
  logic            af_next;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Read pointer crosses clock domains only through this flop chain.
  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_sync[i] <= '0;
      end
    end else begin
      rq_sync[0] <= r_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rq_sync[i] <= rq_sync[i-1];
      end
    end
  end

  always_comb begin
    rq_last      = rq_sync[SYNC_STAGES-1];
    rq_bin       = gray2bin(rq_last);
    w_inc        = w_en & ~full_flag;
    w_bin_next   = w_bin + {{ADDR_W{1'b0}}, w_inc};
    w_gray_next  = (w_bin_next >> 1) ^ w_bin_next;
    // Full when the write pointer has lapped the read pointer exactly once.
    full_match   = {~rq_last[ADDR_W:ADDR_W-1], rq_last[ADDR_W-2:0]};
    full_next    = (w_gray_next == full_match);
    w_level_next = w_bin_next - rq_bin;
    af_next      = (w_level_next >= AF_THR);
  end

  always_ff @(posedge w_clk or posedge rst) begin
    if (rst) begin
      w_bin       <= '0;
      w_gray      <= '0;
      full_flag   <= 1'b0;
      w_level     <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      w_bin       <= w_bin_next;
      w_gray      <= w_gray_next;
      full_flag   <= full_next;
      w_level     <= w_level_next;
      almost_full <= af_next;
      if (w_en && full_flag) begin
        overflow <= 1'b1;
      end
    end
  end

  assign w_ptr = w_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios plus randomized traffic,
// compared against an occupancy-counting reference model.
module tb_wptr_full_ctrl;
  localparam int AW    = 4;
  localparam int S     = 2;
  localparam int AF    = 12;
  localparam int DEPTH = 16;

  // clock / reset
  logic          w_clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic [AW:0]   r_gray_async;
  logic [AW-1:0] w_ptr;
  logic [AW:0]   w_gray;
  logic          full_flag;
  logic          almost_full;
  logic [AW:0]   w_level;
  logic          overflow;

  always #5 w_clk = ~w_clk;

  wptr_full_ctrl #(.ADDR_W(AW), .AF_LEVEL(AF), .SYNC_STAGES(S)) dut (
    .w_clk(w_clk),
    .rst(rst),
    .w_en(w_en),
    .r_gray_async(r_gray_async),
    .w_ptr(w_ptr),
    .w_gray(w_gray),
    .full_flag(full_flag),
    .almost_full(almost_full),
    .w_level(w_level),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: total accepted writes, total reads, delayed read view
  int m_w;
  int r_cnt;
  int m_level;
  bit m_full;
  bit m_af;
  bit m_ovf;
  int rd_pipe[$];

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0;
    r_cnt = 0;
    m_level = 0;
    m_full = 0;
    m_af = 0;
    m_ovf = 0;
    rd_pipe.delete();
    repeat (S) rd_pipe.push_back(0);
  endtask

  task automatic model_edge();
    int used;
    if (w_en && m_full) m_ovf = 1;
    else if (w_en) m_w++;
    used = rd_pipe.pop_front();
    rd_pipe.push_back(r_cnt);
    m_level = (m_w - used) & (2 * DEPTH - 1);
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= AF);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ptr"},   w_ptr,       m_w % DEPTH);
    check({tag, ".gray"},  w_gray,      to_gray(m_w));
    check({tag, ".full"},  full_flag,   m_full);
    check({tag, ".af"},    almost_full, m_af);
    check({tag, ".level"}, w_level,     m_level);
    check({tag, ".ovf"},   overflow,    m_ovf);
  endtask

  // driver: called at a falling edge with w_en / r_cnt already chosen
  task automatic cycle(input string tag);
    r_gray_async = to_gray(r_cnt);
    @(posedge w_clk);
    model_edge();
    @(negedge w_clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w_en = 1'b0;
    r_gray_async = '0;
    model_reset();
    @(posedge w_clk);
    @(negedge w_clk);
    check_all("rst");
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int start_w;
    int occ;
    rst = 1'b1;
    w_en = 1'b0;
    r_gray_async = '0;
    model_reset();
    #1;
    check_all("rst_async");
    @(negedge w_clk);
    rst = 1'b0;

    // fill to full with the reader idle
    w_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cycle("fill");
      if (i == 10) check("af_before_12", almost_full, 1'b0);
      if (i == 11) check("af_at_12", almost_full, 1'b1);
    end
    check("full_gray", w_gray, 5'b11000);
    check("full_flag", full_flag, 1'b1);
    check("full_level", w_level, 16);
    check("full_ptr", w_ptr, 0);

    // writes while full are dropped and flagged
    repeat (3) cycle("ovf");
    check("ovf_gray", w_gray, 5'b11000);
    check("ovf_set", overflow, 1'b1);
    w_en = 1'b0;
    cycle("ovf_hold");
    check("ovf_sticky", overflow, 1'b1);

    // one read; visible after S+1 edges
    r_cnt = 1;
    cycle("rd_lag1");
    check("rd_lag1_full", full_flag, 1'b1);
    cycle("rd_lag2");
    check("rd_lag2_full", full_flag, 1'b1);
    cycle("rd_lag3");
    check("rd_lag3_full", full_flag, 1'b0);
    check("rd_lag3_level", w_level, 15);
    check("rd_lag3_af", almost_full, 1'b1);

    // write coincides with read arrival at level 12
    do_reset();
    w_en = 1'b1;
    repeat (12) cycle("to12");
    w_en = 1'b0;
    r_cnt = 1;
    cycle("hold12a");
    cycle("hold12b");
    w_en = 1'b1;
    cycle("coincide");
    check("coincide_level", w_level, 12);
    check("coincide_af", almost_full, 1'b1);

    // asynchronous reset mid-burst at level 7
    do_reset();
    w_en = 1'b1;
    repeat (7) cycle("to7");
    check("pre_arst_level", w_level, 7);
    #2;
    rst = 1'b1;
    r_gray_async = '0;
    #1;
    check("arst.ptr", w_ptr, 0);
    check("arst.gray", w_gray, 0);
    check("arst.full", full_flag, 0);
    check("arst.af", almost_full, 0);
    check("arst.level", w_level, 0);
    check("arst.ovf", overflow, 0);
    model_reset();
    @(posedge w_clk);
    @(negedge w_clk);
    rst = 1'b0;
    check("post_arst_ptr0", w_ptr, 0);
    cycle("post_arst");
    check("post_arst_ptr1", w_ptr, 1);

    // streaming with occupancy held in 4..10, crossing the pointer wrap
    start_w = m_w;
    for (int c = 0; c < 500 && (m_w - start_w) < 40; c++) begin
      occ = m_w - r_cnt;
      w_en = (occ < 10) && ($urandom_range(0, 3) != 0);
      if (occ > 4 && $urandom_range(0, 1) == 1) r_cnt++;
      cycle("stream");
      check("stream_nofull", full_flag, 1'b0);
    end
    check("stream_done", (m_w - start_w) >= 40, 1'b1);

    // unconstrained random traffic, including full and overflow
    for (int c = 0; c < 300; c++) begin
      w_en = ($urandom_range(0, 3) != 0);
      if (r_cnt < m_w && $urandom_range(0, 2) == 0) r_cnt++;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
